// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with operand forwarding, single-cycle ALU and an
// iterative multiply/divide unit that writes an internal HI/LO pair.
// Optional build macro: EX_FAST_MUL_EN -- MULT/MULTU use a combinational
// multiplier and write HI/LO at the issue edge; divide stays iterative.
//
// state | meaning
// IDLE  | unit free, accepts a multiply/divide issue
// RUN   | one shift-add / restoring-subtract step per cycle, cnt 0..WIDTH-1
// FIX   | sign correction, HI/LO write, back to IDLE
module ex_stage_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [3:0]       Op,
  input  logic [1:0]       FwdSelA,
  input  logic [1:0]       FwdSelB,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [WIDTH-1:0] FwdMEM,
  input  logic [WIDTH-1:0] FwdWB,
  input  logic [WIDTH-1:0] MemReadData,
  input  logic [WIDTH-1:0] Imm,
  input  logic             ALUSrc,
  input  logic [SHW-1:0]   Shamt,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] FwdB_Out,
  output logic             Stall,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdStateT;

  mdStateT            state, stateNext;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               opDiv, negLo, negHi, divZero;
  logic [WIDTH-1:0]   hi, lo;

  logic [WIDTH-1:0]   opA, opBf, opB, aluRes, magA, magB;
  logic               signA, signB, isMd, isMul, isSigned, issue, slowIssue;
  logic [WIDTH:0]     mulSum, divTrial;
  logic [2*WIDTH-1:0] mulNext, divNext;

  // Operand forwarding muxes; B before the ALUSrc mux doubles as store data
  always_comb begin
    case (FwdSelA)
      2'd0:    opA = RD1;
      2'd1:    opA = FwdMEM;
      2'd2:    opA = FwdWB;
      default: opA = MemReadData;
    endcase
    case (FwdSelB)
      2'd0:    opBf = RD2;
      2'd1:    opBf = FwdMEM;
      2'd2:    opBf = FwdWB;
      default: opBf = MemReadData;
    endcase
    opB = ALUSrc ? Imm : opBf;
  end

  // Single-cycle ALU; multiply/divide ops return 0, MFHI/MFLO the registered pair
  always_comb begin
    aluRes = '0;
    case (Op)
      4'd0:  aluRes = opA + opB;
      4'd1:  aluRes = opA - opB;
      4'd2:  aluRes = opA & opB;
      4'd3:  aluRes = opA | opB;
      4'd4:  aluRes = opA ^ opB;
      4'd5:  aluRes = ~(opA | opB);
      4'd6:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
      4'd7:  aluRes = opBf << Shamt;
      4'd8:  aluRes = opBf >> Shamt;
      4'd9:  aluRes = $signed(opBf) >>> Shamt;
      4'd14: aluRes = hi;
      4'd15: aluRes = lo;
      default: aluRes = '0;
    endcase
  end

  assign Result   = aluRes;
  assign Zero     = (aluRes == '0);
  assign FwdB_Out = opBf;

  assign isMd     = (Op >= 4'd10) && (Op <= 4'd13);
  assign isMul    = (Op == 4'd10) || (Op == 4'd11);
  assign isSigned = (Op == 4'd10) || (Op == 4'd12);
  assign signA    = isSigned & opA[WIDTH-1];
  assign signB    = isSigned & opBf[WIDTH-1];
  assign magA     = signA ? -opA : opA;
  assign magB     = signB ? -opBf : opBf;
  assign issue    = InValid && (state == IDLE) && isMd;
  assign Busy     = (state != IDLE);
  assign Stall    = InValid & Busy & (Op >= 4'd10);

`ifdef EX_FAST_MUL_EN
  logic               fastIssue;
  logic [2*WIDTH-1:0] fastProd;
  assign fastIssue = issue && isMul;
  assign slowIssue = issue && !isMul;
  // Low 2*WIDTH bits of the extended product are correct for signed and unsigned
  assign fastProd  = isSigned ?
                     ({{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opBf[WIDTH-1]}}, opBf}) :
                     ({{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opBf});
`else
  assign slowIssue = issue;
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mulNext  = {mulSum, acc[WIDTH-1:1]};
    divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
    divNext  = divTrial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (slowIssue) stateNext = RUN;
      RUN:     if (cnt == SHW'(WIDTH-1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Iteration datapath and HI/LO; a reset mid-operation discards everything
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      opDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (slowIssue) begin
            cnt     <= '0;
            mcand   <= isMul ? magA : magB;
            acc     <= isMul ? {{WIDTH{1'b0}}, magB} : {{WIDTH{1'b0}}, magA};
            opDiv   <= !isMul;
            negLo   <= signA ^ signB;
            negHi   <= isMul ? (signA ^ signB) : signA;
            divZero <= (opBf == '0);
          end
`ifdef EX_FAST_MUL_EN
          if (fastIssue) {hi, lo} <= fastProd;
`endif
        end
        RUN: begin
          acc <= opDiv ? divNext : mulNext;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!opDiv) begin
            {hi, lo} <= negLo ? -acc : acc;
          end else begin
            // Remainder carries the dividend sign, so divide by zero leaves HI = A
            hi <= negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo <= divZero ? '1 : (negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc (WIDTH = 32): random ALU traffic and
// directed plus random multiply/divide checked against an arithmetic model.
module tb_ex_stage_mc;
  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic [3:0]    Op = 4'd0;
  logic [1:0]    FwdSelA = 2'd0, FwdSelB = 2'd0;
  logic [W-1:0]  RD1 = '0, RD2 = '0, FwdMEM = '0, FwdWB = '0, MemReadData = '0, Imm = '0;
  logic          ALUSrc = 1'b0;
  logic [4:0]    Shamt = '0;
  logic [W-1:0]  Result, FwdB_Out;
  logic          Zero, Stall, Busy;

  int nChecks = 0;
  int nErrors = 0;

  ex_stage_mc #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .Op(Op),
    .FwdSelA(FwdSelA), .FwdSelB(FwdSelB), .RD1(RD1), .RD2(RD2),
    .FwdMEM(FwdMEM), .FwdWB(FwdWB), .MemReadData(MemReadData), .Imm(Imm),
    .ALUSrc(ALUSrc), .Shamt(Shamt), .Result(Result), .Zero(Zero),
    .FwdB_Out(FwdB_Out), .Stall(Stall), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rd);
    case (s)
      2'd0:    return rd;
      2'd1:    return FwdMEM;
      2'd2:    return FwdWB;
      default: return MemReadData;
    endcase
  endfunction

  function automatic logic [31:0] aluRef(input int op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] bf, input int sh);
    int sa, sb, sbf;
    sa = a; sb = b; sbf = bf;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return (sa < sb) ? 32'd1 : 32'd0;
      7: return bf << sh;
      8: return bf >> sh;
      9: return sbf >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] mdRef(input int op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib, q, r;
    longint la, lb;
    logic [31:0] qb, rb;
    ia = a; ib = b; la = ia; lb = ib;
    case (op)
      10: return la * lb;
      11: return {32'd0, a} * {32'd0, b};
      12: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib; r = ia % ib; qb = q; rb = r;
        return {rb, qb};
      end
      13: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        qb = a / b; rb = a % b;
        return {rb, qb};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue a multiply/divide in the current cycle (called at posedge+1), run an
  // ADD in the next cycle, then hold MFHI until it proceeds and read MFLO after.
  task automatic runMd(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int expBusy, stallCnt, busyCnt;
    exp = mdRef(op, a, b);
    expBusy = W + 1;
`ifdef EX_FAST_MUL_EN
    if (op < 12) expBusy = 0;
`endif
    Op = 4'(op); InValid = 1'b1; FwdSelA = 2'd0; FwdSelB = 2'd0;
    RD1 = a; RD2 = b; ALUSrc = 1'($urandom);
    @(negedge Clock);
    chk({tag, " issue stall"}, {63'd0, Stall}, 64'd0);
    chk({tag, " issue result"}, {32'd0, Result}, 64'd0);
    step();
    busyCnt = 0;
    Op = 4'd0; RD1 = $urandom; RD2 = $urandom; ALUSrc = 1'b0;
    @(negedge Clock);
    chk({tag, " add no stall"}, {63'd0, Stall}, 64'd0);
    chk({tag, " add result"}, {32'd0, Result}, {32'd0, RD1 + RD2});
    if (Busy) busyCnt++;
    step();
    Op = 4'd14;
    stallCnt = 0;
    @(negedge Clock);
    while (Stall && stallCnt < 200) begin
      if (stallCnt == 5) begin
        InValid = 1'b0;
        #1 chk({tag, " stall drops with InValid"}, {62'd0, Stall, Busy}, 64'd1);
        InValid = 1'b1;
        #1;
      end
      stallCnt++;
      if (Busy) busyCnt++;
      step();
      @(negedge Clock);
    end
    chk({tag, " stall cycles"}, 64'(stallCnt), 64'((expBusy == 0) ? 0 : expBusy - 1));
    chk({tag, " busy cycles"}, 64'(busyCnt), 64'(expBusy));
    chk({tag, " busy low"}, {63'd0, Busy}, 64'd0);
    chk({tag, " MFHI"}, {32'd0, Result}, {32'd0, exp[63:32]});
    step();
    Op = 4'd15;
    @(negedge Clock);
    chk({tag, " MFLO"}, {32'd0, Result}, {32'd0, exp[31:0]});
    chk({tag, " MFLO stall"}, {63'd0, Stall}, 64'd0);
    step();
  endtask

  initial begin
    logic [31:0] a, bf, b, exp;
    int op;

    // Reset state
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0; InValid = 1'b1; Op = 4'd14;
    #1;
    chk("reset busy", {63'd0, Busy}, 64'd0);
    chk("reset stall", {63'd0, Stall}, 64'd0);
    chk("reset HI", {32'd0, Result}, 64'd0);
    Op = 4'd15;
    #1 chk("reset LO", {32'd0, Result}, 64'd0);
    step();

    // Forwarding example
    FwdSelA = 2'd1; FwdMEM = 32'h7; FwdSelB = 2'd0; RD2 = 32'd3; ALUSrc = 1'b0; Op = 4'd1;
    #1;
    chk("fwd SUB", {32'd0, Result}, 64'd4);
    chk("fwd SUB zero", {63'd0, Zero}, 64'd0);
    chk("fwd B out", {32'd0, FwdB_Out}, 64'd3);
    ALUSrc = 1'b1; Imm = 32'hFFFF_FFFF; Op = 4'd0;
    #1 chk("imm ADD", {32'd0, Result}, 64'd6);
    FwdSelA = 2'd0; RD1 = 32'h1234_5678; FwdSelB = 2'd2; FwdWB = 32'h1234_5678;
    ALUSrc = 1'b0; Op = 4'd4;
    #1;
    chk("xor zero result", {32'd0, Result}, 64'd0);
    chk("xor zero flag", {63'd0, Zero}, 64'd1);
    step();

    // Random ALU traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      Op = 4'(op); FwdSelA = 2'($urandom); FwdSelB = 2'($urandom);
      RD1 = $urandom; RD2 = $urandom; FwdMEM = $urandom; FwdWB = $urandom;
      MemReadData = $urandom; Imm = $urandom; ALUSrc = 1'($urandom);
      Shamt = 5'($urandom); InValid = 1'($urandom);
      if (i % 7 == 0) RD2 = RD1;
      a = pick(FwdSelA, RD1); bf = pick(FwdSelB, RD2); b = ALUSrc ? Imm : bf;
      exp = aluRef(op, a, b, bf, int'(Shamt));
      @(negedge Clock);
      chk("alu result", {32'd0, Result}, {32'd0, exp});
      chk("alu zero", {63'd0, Zero}, {63'd0, (exp == 0)});
      chk("alu fwdB", {32'd0, FwdB_Out}, {32'd0, bf});
      chk("alu stall", {63'd0, Stall}, 64'd0);
      step();
    end

    // Directed multiply/divide
    runMd(10, 32'hFFFF_FFFD, 32'd5, "MULT -3*5");
    runMd(12, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    runMd(13, 32'd7, 32'd0, "DIVU 7/0");
    runMd(12, 32'hFFFF_FFF9, 32'd0, "DIV -7/0");
    runMd(12, 32'h8000_0000, 32'hFFFF_FFFF, "DIV min/-1");
    runMd(12, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2");
    runMd(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULTU max");
    runMd(10, 32'hFFFF_FFFD, 32'd5, "MULT again");

    // Reset in the middle of a DIVU at cnt=10
    Op = 4'd13; InValid = 1'b1; FwdSelA = 2'd0; FwdSelB = 2'd0;
    RD1 = 32'hDEAD_BEEF; RD2 = 32'd3;
    step();
    Op = 4'd0;
    for (int i = 0; i < 10; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; Op = 4'd14;
    #1;
    chk("mid reset busy", {63'd0, Busy}, 64'd0);
    chk("mid reset HI", {32'd0, Result}, 64'd0);
    Op = 4'd15;
    #1 chk("mid reset LO", {32'd0, Result}, 64'd0);
    runMd(11, 32'h0001_0003, 32'h0002_0005, "MULTU after reset");

    // Random multiply/divide
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(10, 13);
      a = $urandom;
      bf = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom));
      if (i % 3 == 0 && op == 12) bf = -bf;
      runMd(op, a, bf, "random md");
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
